// File: rtl/ring_seq_if.sv
// Phase bus from the ring counter plus the checker's status outputs.
// The master modport drives the phase bus; the slave modport is the checker.
interface ring_seq_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8,
    parameter int ERR_W = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] phase;
    logic             phase_valid;
    logic             clr_err;
    logic             locked;
    logic [IDX_W-1:0] cur_index;
    logic [REV_W-1:0] rev_count;
    logic             rev_pulse;
    logic [ERR_W-1:0] err_count;
    logic             err_flag;
    logic             lost_pulse;

    modport master (
        output phase, phase_valid, clr_err,
        input  locked, cur_index, rev_count, rev_pulse, err_count, err_flag, lost_pulse
    );

    modport slave (
        input  phase, phase_valid, clr_err,
        output locked, cur_index, rev_count, rev_pulse, err_count, err_flag, lost_pulse
    );
endinterface

// File: rtl/ring_sequence_checker.sv
// Checks that a one-hot ring counter rotates left by exactly one step per valid
// sample; tracks lock, revolutions and error statistics, and re-acquires lock.
module ring_sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int REV_W      = 8,
    parameter int ERR_W      = 8,
    parameter int LOCK_STEPS = 2,
    parameter int ERR_LIMIT  = 3
) (
    input  logic         clk,
    input  logic         reset,
    ring_seq_if.slave    bus
);
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_STEPS + 1);
    localparam int MISS_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [IDX_W-1:0]    cur_index_q, cur_index_d;
    logic [REV_W-1:0]    rev_count_q, rev_count_d;
    logic                rev_pulse_q, rev_pulse_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic                err_flag_q, err_flag_d;
    logic                lost_pulse_q, lost_pulse_d;

    logic                is_onehot;
    logic                is_correct;
    logic [WIDTH-1:0]    expected;
    logic [IDX_W-1:0]    phase_idx;
    logic [IDX_W-1:0]    idx_terms [WIDTH];
    logic [GOOD_W-1:0]   good_inc;
    logic [MISS_W-1:0]   miss_inc;

    // Each set bit contributes its own position; for a one-hot input the OR is the index.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_idx
        assign idx_terms[gi] = bus.phase[gi] ? IDX_W'(gi) : '0;
    end

    always_comb begin
        phase_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            phase_idx = phase_idx | idx_terms[i];
        end
    end

    assign is_onehot  = (bus.phase != '0) && ((bus.phase & (bus.phase - WIDTH'(1))) == '0);
    assign expected   = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign is_correct = is_onehot && (bus.phase == expected) && (prev_q != '0);
    assign good_inc   = good_cnt_q + GOOD_W'(1);
    assign miss_inc   = miss_cnt_q + MISS_W'(1);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_cnt_d   = good_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        cur_index_d  = cur_index_q;
        rev_count_d  = rev_count_q;
        rev_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        err_flag_d   = err_flag_q;
        lost_pulse_d = 1'b0;

        if (bus.phase_valid) begin
            // Any legal one-hot position re-anchors the expected next step.
            if (is_onehot) begin
                prev_d      = bus.phase;
                cur_index_d = phase_idx;
            end

            case (state_q)
                HUNT: begin
                    if (is_correct) begin
                        if (good_inc == GOOD_W'(LOCK_STEPS)) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_inc;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (is_correct) begin
                        miss_cnt_d = '0;
                        if (bus.phase[WIDTH-1]) begin
                            rev_count_d = rev_count_q + REV_W'(1);
                            rev_pulse_d = 1'b1;
                        end
                    end else begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        err_flag_d = 1'b1;
                        if (miss_inc == MISS_W'(ERR_LIMIT)) begin
                            state_d      = HUNT;
                            lost_pulse_d = 1'b1;
                            good_cnt_d   = '0;
                            miss_cnt_d   = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clearing wins over a same-cycle error increment.
        if (bus.clr_err) begin
            err_count_d = '0;
            err_flag_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            good_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            cur_index_q  <= '0;
            rev_count_q  <= '0;
            rev_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            lost_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_cnt_q   <= good_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            cur_index_q  <= cur_index_d;
            rev_count_q  <= rev_count_d;
            rev_pulse_q  <= rev_pulse_d;
            err_count_q  <= err_count_d;
            err_flag_q   <= err_flag_d;
            lost_pulse_q <= lost_pulse_d;
        end
    end

    assign bus.locked     = (state_q == LOCKED);
    assign bus.cur_index  = cur_index_q;
    assign bus.rev_count  = rev_count_q;
    assign bus.rev_pulse  = rev_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.err_flag   = err_flag_q;
    assign bus.lost_pulse = lost_pulse_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed scenarios for ring_sequence_checker (WIDTH=4, LOCK_STEPS=2, ERR_LIMIT=3)
// with hand-computed expected values.
module tb_ring_sequence_checker;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    ring_seq_if #(.WIDTH(4), .REV_W(8), .ERR_W(8)) bus ();

    ring_sequence_checker #(
        .WIDTH(4), .REV_W(8), .ERR_W(8), .LOCK_STEPS(2), .ERR_LIMIT(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [3:0] ph, input logic v, input logic clr);
        @(negedge clk);
        bus.phase       = ph;
        bus.phase_valid = v;
        bus.clr_err     = clr;
        @(posedge clk);
        #1;
        $display("t=%0t ph=%b v=%b clr=%b locked=%b idx=%0d rev=%0d rp=%b err=%0d ef=%b lp=%b",
                 $time, ph, v, clr, bus.locked, bus.cur_index, bus.rev_count,
                 bus.rev_pulse, bus.err_count, bus.err_flag, bus.lost_pulse);
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.phase       = 4'b0000;
        bus.phase_valid = 1'b0;
        bus.clr_err     = 1'b0;
        #15;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic lock_seq();
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
    endtask

    task automatic full_rev();
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.phase       = 4'b0001;
        bus.phase_valid = 1'b1;
        bus.clr_err     = 1'b0;
        #12;
        total++; if (bus.locked     !== 1'b0)  $display("FAIL reset_locked got %b want 0", bus.locked);     else passed++;
        total++; if (bus.cur_index  !== 2'd0)  $display("FAIL reset_idx got %0d want 0", bus.cur_index);    else passed++;
        total++; if (bus.rev_count  !== 8'd0)  $display("FAIL reset_rev got %0d want 0", bus.rev_count);    else passed++;
        total++; if (bus.rev_pulse  !== 1'b0)  $display("FAIL reset_rp got %b want 0", bus.rev_pulse);      else passed++;
        total++; if (bus.err_count  !== 8'd0)  $display("FAIL reset_err got %0d want 0", bus.err_count);    else passed++;
        total++; if (bus.err_flag   !== 1'b0)  $display("FAIL reset_ef got %b want 0", bus.err_flag);       else passed++;
        total++; if (bus.lost_pulse !== 1'b0)  $display("FAIL reset_lp got %b want 0", bus.lost_pulse);     else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        step(4'b1000, 1'b1, 1'b0);
        total++; if (bus.locked    !== 1'b0) $display("FAIL lock_s1_locked got %b want 0", bus.locked);   else passed++;
        total++; if (bus.cur_index !== 2'd3) $display("FAIL lock_s1_idx got %0d want 3", bus.cur_index); else passed++;
        step(4'b0001, 1'b1, 1'b0);
        total++; if (bus.locked    !== 1'b0) $display("FAIL lock_s2_locked got %b want 0", bus.locked);   else passed++;
        step(4'b0010, 1'b1, 1'b0);
        total++; if (bus.locked    !== 1'b1) $display("FAIL lock_s3_locked got %b want 1", bus.locked);   else passed++;
        total++; if (bus.cur_index !== 2'd1) $display("FAIL lock_s3_idx got %0d want 1", bus.cur_index); else passed++;
        total++; if (bus.err_count !== 8'd0) $display("FAIL lock_err got %0d want 0", bus.err_count);    else passed++;
        total++; if (bus.rev_count !== 8'd0) $display("FAIL lock_rev got %0d want 0", bus.rev_count);    else passed++;
    endtask

    task automatic test_revolution();
        step(4'b0100, 1'b1, 1'b0);
        total++; if (bus.rev_pulse !== 1'b0) $display("FAIL rev_pre_pulse got %b want 0", bus.rev_pulse); else passed++;
        step(4'b1000, 1'b1, 1'b0);
        total++; if (bus.rev_pulse !== 1'b1) $display("FAIL rev_pulse got %b want 1", bus.rev_pulse);     else passed++;
        total++; if (bus.rev_count !== 8'd1) $display("FAIL rev_count1 got %0d want 1", bus.rev_count);   else passed++;
        step(4'b0001, 1'b1, 1'b0);
        total++; if (bus.rev_pulse !== 1'b0) $display("FAIL rev_pulse_once got %b want 0", bus.rev_pulse); else passed++;
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) full_rev();
        total++; if (bus.rev_count !== 8'd5) $display("FAIL rev_count5 got %0d want 5", bus.rev_count);   else passed++;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            total++;
            if (bus.locked !== 1'b1 || bus.rev_count !== 8'd5 || bus.rev_pulse !== 1'b0 ||
                bus.err_count !== 8'd0 || bus.cur_index !== 2'd3)
                $display("FAIL idle_hold%0d got locked=%b rev=%0d rp=%b err=%0d idx=%0d want 1/5/0/0/3",
                         i, bus.locked, bus.rev_count, bus.rev_pulse, bus.err_count, bus.cur_index);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        lock_seq();
        step(4'b0011, 1'b1, 1'b0);
        total++; if (bus.err_count !== 8'd1) $display("FAIL glitch_err got %0d want 1", bus.err_count);  else passed++;
        total++; if (bus.err_flag  !== 1'b1) $display("FAIL glitch_ef got %b want 1", bus.err_flag);     else passed++;
        total++; if (bus.locked    !== 1'b1) $display("FAIL glitch_locked got %b want 1", bus.locked);   else passed++;
        total++; if (bus.cur_index !== 2'd1) $display("FAIL glitch_idx got %0d want 1", bus.cur_index); else passed++;
        step(4'b0100, 1'b1, 1'b0);
        total++; if (bus.err_count !== 8'd1) $display("FAIL glitch_accept_err got %0d want 1", bus.err_count); else passed++;
        total++; if (bus.cur_index !== 2'd2) $display("FAIL glitch_accept_idx got %0d want 2", bus.cur_index); else passed++;
        // Two more misses must not drop lock if the miss count was cleared.
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        total++; if (bus.locked     !== 1'b1) $display("FAIL glitch_miss_reset got %b want 1", bus.locked);    else passed++;
        total++; if (bus.lost_pulse !== 1'b0) $display("FAIL glitch_lp got %b want 0", bus.lost_pulse);       else passed++;
        total++; if (bus.err_count  !== 8'd3) $display("FAIL glitch_err3 got %0d want 3", bus.err_count);     else passed++;
    endtask

    task automatic test_loss_relock();
        do_reset();
        lock_seq();
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        total++; if (bus.locked     !== 1'b1) $display("FAIL loss_2nd_locked got %b want 1", bus.locked);  else passed++;
        step(4'b0000, 1'b1, 1'b0);
        total++; if (bus.lost_pulse !== 1'b1) $display("FAIL loss_lp got %b want 1", bus.lost_pulse);      else passed++;
        total++; if (bus.locked     !== 1'b0) $display("FAIL loss_locked got %b want 0", bus.locked);      else passed++;
        total++; if (bus.err_count  !== 8'd3) $display("FAIL loss_err got %0d want 3", bus.err_count);     else passed++;
        step(4'b0001, 1'b1, 1'b0);
        total++; if (bus.lost_pulse !== 1'b0) $display("FAIL loss_lp_once got %b want 0", bus.lost_pulse); else passed++;
        step(4'b0010, 1'b1, 1'b0);
        total++; if (bus.locked     !== 1'b0) $display("FAIL relock_early got %b want 0", bus.locked);     else passed++;
        step(4'b0100, 1'b1, 1'b0);
        total++; if (bus.locked     !== 1'b1) $display("FAIL relock got %b want 1", bus.locked);           else passed++;
        total++; if (bus.err_count  !== 8'd3) $display("FAIL relock_err got %0d want 3", bus.err_count);   else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        lock_seq();
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) full_rev();
        total++; if (bus.rev_count !== 8'd7) $display("FAIL areset_pre_rev got %0d want 7", bus.rev_count); else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.locked !== 1'b0 || bus.cur_index !== 2'd0 || bus.rev_count !== 8'd0 ||
            bus.rev_pulse !== 1'b0 || bus.err_count !== 8'd0 || bus.err_flag !== 1'b0 ||
            bus.lost_pulse !== 1'b0)
            $display("FAIL areset_outputs got locked=%b idx=%0d rev=%0d rp=%b err=%0d ef=%b lp=%b want all 0",
                     bus.locked, bus.cur_index, bus.rev_count, bus.rev_pulse, bus.err_count,
                     bus.err_flag, bus.lost_pulse);
        else passed++;
        bus.phase_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        total++; if (bus.locked !== 1'b0) $display("FAIL areset_relock_early got %b want 0", bus.locked); else passed++;
        step(4'b0010, 1'b1, 1'b0);
        total++; if (bus.locked !== 1'b1) $display("FAIL areset_relock got %b want 1", bus.locked);       else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        lock_seq();
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        for (int i = 0; i < 254; i++) full_rev();
        total++; if (bus.rev_count !== 8'd255) $display("FAIL wrap_255 got %0d want 255", bus.rev_count); else passed++;
        full_rev();
        total++; if (bus.rev_count !== 8'd0)   $display("FAIL wrap_0 got %0d want 0", bus.rev_count);     else passed++;
        total++; if (bus.rev_pulse !== 1'b1)   $display("FAIL wrap_pulse got %b want 1", bus.rev_pulse);  else passed++;
    endtask

    task automatic test_clr_err();
        logic [3:0] pos;
        do_reset();
        lock_seq();
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        total++; if (bus.err_count !== 8'd5) $display("FAIL clr_pre_err got %0d want 5", bus.err_count); else passed++;
        total++; if (bus.locked    !== 1'b1) $display("FAIL clr_pre_locked got %b want 1", bus.locked);  else passed++;
        step(4'b0000, 1'b1, 1'b1);
        total++; if (bus.err_count !== 8'd0) $display("FAIL clr_err got %0d want 0", bus.err_count);    else passed++;
        total++; if (bus.err_flag  !== 1'b0) $display("FAIL clr_ef got %b want 0", bus.err_flag);       else passed++;
        step(4'b0000, 1'b1, 1'b0);
        total++; if (bus.locked    !== 1'b1) $display("FAIL clr_miss2_locked got %b want 1", bus.locked); else passed++;
        step(4'b0000, 1'b1, 1'b0);
        total++; if (bus.locked    !== 1'b0) $display("FAIL clr_miss3_locked got %b want 0", bus.locked); else passed++;
        total++; if (bus.err_count !== 8'd2) $display("FAIL clr_post_err got %0d want 2", bus.err_count); else passed++;

        // 100 relock/lose cycles add 300 more errors, well past saturation.
        pos = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            for (int j = 0; j < 3; j++) begin
                pos = {pos[2:0], pos[3]};
                step(pos, 1'b1, 1'b0);
            end
            for (int j = 0; j < 3; j++) step(4'b0000, 1'b1, 1'b0);
        end
        total++; if (bus.err_count !== 8'd255) $display("FAIL sat_err got %0d want 255", bus.err_count); else passed++;
        total++; if (bus.err_flag  !== 1'b1)   $display("FAIL sat_ef got %b want 1", bus.err_flag);     else passed++;
        total++; if (bus.locked    !== 1'b0)   $display("FAIL sat_locked got %b want 0", bus.locked);   else passed++;
        step(4'b0000, 1'b0, 1'b1);
        total++; if (bus.err_count !== 8'd0)   $display("FAIL clr_novalid_err got %0d want 0", bus.err_count); else passed++;
        total++; if (bus.err_flag  !== 1'b0)   $display("FAIL clr_novalid_ef got %b want 0", bus.err_flag);   else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_lock();
        test_revolution();
        test_glitch();
        test_loss_relock();
        test_async_reset();
        test_wrap();
        test_clr_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
